sdram_frame_writer: RTL and testbench
=====================================

Name: sdram_frame_writer

Overview:
- Upstream feeder for the 4-port SDRAM controller's two write sides. Takes a 30-bit RGB pixel stream from the CCD capture and RAW-to-RGB pipeline, qualified by frame, line and data valids.
- Packs each pixel into two 16-bit words, one per write FIFO, and drives the controller's WR1/WR2 data, request, address, length and load inputs.
- Per frame it reloads the write address registers and clears the FIFOs, guards against FIFO overflow, and keeps frame and drop statistics.

Parameters:
- ASIZE, 22, SDRAM word address width.
- WR1_BASE, 22'h000000, frame start address for write side 1.
- WR2_BASE, 22'h100000, frame start address for write side 2.
- FRAME_PIXELS, 327680, expected pixels per frame (640*512).
- BURST_LEN, 256, value driven on WRx_LENGTH (9 bits, 1..256).
- LOAD_CYCLES, 4, width of the WRx_LOAD pulse in CLK cycles (1..15).

Ports:
- CLK  in  1  pixel/write-side clock; also drives WR1_CLK/WR2_CLK externally.
- RESET  in  1  asynchronous reset, active-high.
- iENABLE  in  1  capture enable, level.
- iFVAL  in  1  frame valid.
- iLVAL  in  1  line valid.
- iDVAL  in  1  pixel valid.
- iRED  in  10  red.
- iGREEN  in  10  green.
- iBLUE  in  10  blue.
- iWR1_FULL  in  1  write FIFO 1 full.
- iWR2_FULL  in  1  write FIFO 2 full.
- WR1_DATA  out  16  {1'b0,G[9:5],B[9:0]}.
- WR2_DATA  out  16  {1'b0,G[4:0],R[9:0]}.
- WR1  out  1  write request, FIFO 1.
- WR2  out  1  write request, FIFO 2.
- WR1_ADDR, WR2_ADDR  out  ASIZE  WR1_BASE / WR2_BASE.
- WR1_MAX_ADDR, WR2_MAX_ADDR  out  ASIZE  base+FRAME_PIXELS.
- WR1_LENGTH, WR2_LENGTH  out  9  BURST_LEN.
- WR1_LOAD, WR2_LOAD  out  1  address reload and FIFO clear.
- oFRAME_CNT  out  16  completed frames, wraps at 16'hFFFF->0.
- oDROP_CNT  out  16  pixels dropped this frame, saturates at 16'hFFFF.
- oOVERFLOW  out  1  sticky: a drop occurred this frame.
- oSIZE_ERR  out  1  last frame pixel count != FRAME_PIXELS.
- oBUSY  out  1  state != IDLE.

Behaviour:
- Reset values:
  - FSM = IDLE; all counters 0.
  - WR1, WR2, WRx_LOAD, oOVERFLOW, oSIZE_ERR, oBUSY = 0.
  - WRx_DATA = 0.
- Address, max-address and length outputs are constants derived from parameters.
- iFVAL is registered once (fval_d); frame start = iFVAL & ~fval_d; frame end = ~iFVAL & fval_d.
- IDLE:
  - iENABLE=1 -> SYNC.
- SYNC (avoids capturing a partial frame):
  - Wait for iFVAL=0, then -> ARMED.
- ARMED:
  - On frame start -> LOAD.
  - iENABLE=0 -> IDLE.
- LOAD:
  - WR1_LOAD = WR2_LOAD = 1 for exactly LOAD_CYCLES cycles; a down-counter is loaded on entry.
  - On entry clear oDROP_CNT, oOVERFLOW and the pixel counter.
  - Pixels arriving in LOAD are not written; they count as drops and set oOVERFLOW.
  - Then -> ACTIVE.
  - If frame end occurs during LOAD, finish the pulse, then do the frame-end actions.
- ACTIVE:
  - On sampled iFVAL&iLVAL&iDVAL:
    - If iWR1_FULL=0 and iWR2_FULL=0, register both packed words and assert WR1 and WR2 together on the next cycle (latency 1, single-cycle pulse per pixel). Increment the pixel counter (20 bits, saturating).
    - Else drop the pixel on both sides so the FIFOs stay aligned; oDROP_CNT += 1 (saturating); oOVERFLOW=1.
  - WR1 and WR2 are always identical.
- Frame end (from ACTIVE or after LOAD):
  - oFRAME_CNT += 1.
  - oSIZE_ERR = (pixel_cnt != FRAME_PIXELS), evaluated with the final pixel included.
  - -> ARMED if iENABLE=1, else IDLE.
- iENABLE deasserted mid-frame: the current frame completes normally, no truncation.
- Frame start while in ACTIVE cannot occur, because frame end always precedes it.
- Assertion of RESET mid-frame: immediate return to reset values, including a WRx_LOAD pulse cut short. After release the block resyncs via SYNC.
- oDROP_CNT and oOVERFLOW hold after frame end until the next LOAD entry; oSIZE_ERR holds until the next frame end.

Decomposition:
- Shared package sdram_frame_pkg:
  - FSM state enum (IDLE, SYNC, ARMED, LOAD, ACTIVE).
  - Packing function pack_rgb returning the two 16-bit words.
  - ASIZE constant.
- No sub-module; one saturating-counter function in the package is sufficient.

Test Plan:
- Reset, iENABLE=1, iFVAL=0, then rising iFVAL:
  - WR1_LOAD = WR2_LOAD = 1 for exactly 4 cycles.
  - oDROP_CNT = 0, oBUSY = 1.
- One pixel R=10'h3FF, G=10'h2AA, B=10'h155 with FIFOs not full:
  - Next cycle WR1 = WR2 = 1 for 1 cycle.
  - WR1_DATA = 16'h5555, WR2_DATA = 16'h2BFF.
- iWR2_FULL=1 for 3 valid pixels:
  - WR1 = WR2 = 0 for those pixels.
  - oDROP_CNT = 3, oOVERFLOW = 1; both clear at the next LOAD.
- Full frame of 327680 pixels, then iFVAL falls:
  - oFRAME_CNT = 1, oSIZE_ERR = 0.
  - Next frame of 327679 pixels: oSIZE_ERR = 1, oFRAME_CNT = 2.
- Enable while iFVAL=1 mid-frame:
  - No writes until iFVAL falls and rises again.
  - Deassert iENABLE mid-frame: the frame completes and the FSM returns to IDLE.
- Assert RESET during LOAD cycle 2:
  - WRx_LOAD drops immediately.
  - After release with iFVAL=1, no LOAD until a new frame start.

Source files
------------

// File: rtl/sdram_frame_pkg.sv
// Shared types and helpers for the SDRAM frame writer: FSM states, the
// two-word RGB packing and saturating counters.
package sdram_frame_pkg;

    localparam int SDRAM_ASIZE = 22;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ARMED,
        LOAD,
        ACTIVE
    } fw_state_t;

    typedef struct packed {
        logic [15:0] wr1;
        logic [15:0] wr2;
    } wr_words_t;

    // Green is split across both words so each side carries 15 bits of colour.
    function automatic wr_words_t pack_rgb(input logic [9:0] r,
                                           input logic [9:0] g,
                                           input logic [9:0] b);
        wr_words_t w;
        w.wr1 = {1'b0, g[9:5], b};
        w.wr2 = {1'b0, g[4:0], r};
        return w;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

endpackage

// File: rtl/sdram_frame_writer.sv
// Packs the RGB capture stream into two aligned SDRAM write FIFOs, reloads the
// write sides at every frame start and tracks frame/drop statistics.
module sdram_frame_writer
    import sdram_frame_pkg::*;
#(
    parameter int                     ASIZE        = SDRAM_ASIZE,
    parameter logic [ASIZE-1:0]       WR1_BASE     = '0,
    parameter logic [ASIZE-1:0]       WR2_BASE     = ASIZE'(22'h100000),
    parameter int                     FRAME_PIXELS = 327680,
    parameter int                     BURST_LEN    = 256,
    parameter int                     LOAD_CYCLES  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             iENABLE,
    input  logic             iFVAL,
    input  logic             iLVAL,
    input  logic             iDVAL,
    input  logic [9:0]       iRED,
    input  logic [9:0]       iGREEN,
    input  logic [9:0]       iBLUE,
    input  logic             iWR1_FULL,
    input  logic             iWR2_FULL,
    output logic [15:0]      WR1_DATA,
    output logic [15:0]      WR2_DATA,
    output logic             WR1,
    output logic             WR2,
    output logic [ASIZE-1:0] WR1_ADDR,
    output logic [ASIZE-1:0] WR2_ADDR,
    output logic [ASIZE-1:0] WR1_MAX_ADDR,
    output logic [ASIZE-1:0] WR2_MAX_ADDR,
    output logic [8:0]       WR1_LENGTH,
    output logic [8:0]       WR2_LENGTH,
    output logic             WR1_LOAD,
    output logic             WR2_LOAD,
    output logic [15:0]      oFRAME_CNT,
    output logic [15:0]      oDROP_CNT,
    output logic             oOVERFLOW,
    output logic             oSIZE_ERR,
    output logic             oBUSY
);

    localparam logic [19:0] FRAME_PIX = 20'(FRAME_PIXELS);
    localparam logic [3:0]  LOAD_LAST = 4'(LOAD_CYCLES - 1);

    fw_state_t   state;
    logic        fval_d;
    logic [3:0]  load_cnt;
    logic        end_pend;
    logic [19:0] pixel_cnt;
    logic        wr_p1;
    logic [15:0] wr1_data_p1;
    logic [15:0] wr2_data_p1;
    logic        load_r;

    logic        frame_start;
    logic        frame_end;
    logic        pix_vld;
    wr_words_t   words;

    assign frame_start = iFVAL & ~fval_d;
    assign frame_end   = ~iFVAL & fval_d;
    assign pix_vld     = iFVAL & iLVAL & iDVAL;
    assign words       = pack_rgb(iRED, iGREEN, iBLUE);

    assign WR1_ADDR     = WR1_BASE;
    assign WR2_ADDR     = WR2_BASE;
    assign WR1_MAX_ADDR = WR1_BASE + ASIZE'(FRAME_PIXELS);
    assign WR2_MAX_ADDR = WR2_BASE + ASIZE'(FRAME_PIXELS);
    assign WR1_LENGTH   = 9'(BURST_LEN);
    assign WR2_LENGTH   = 9'(BURST_LEN);

    // Both write sides share one request and one load so the FIFOs never skew.
    assign WR1      = wr_p1;
    assign WR2      = wr_p1;
    assign WR1_DATA = wr1_data_p1;
    assign WR2_DATA = wr2_data_p1;
    assign WR1_LOAD = load_r;
    assign WR2_LOAD = load_r;
    assign oBUSY    = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            fval_d      <= 1'b0;
            load_cnt    <= '0;
            end_pend    <= 1'b0;
            pixel_cnt   <= '0;
            wr_p1       <= 1'b0;
            wr1_data_p1 <= '0;
            wr2_data_p1 <= '0;
            load_r      <= 1'b0;
            oFRAME_CNT  <= '0;
            oDROP_CNT   <= '0;
            oOVERFLOW   <= 1'b0;
            oSIZE_ERR   <= 1'b0;
        end else begin
            fval_d <= iFVAL;
            wr_p1  <= 1'b0;

            case (state)
                IDLE: begin
                    if (iENABLE)
                        state <= SYNC;
                end

                // Skip whatever frame is in flight so capture starts on a boundary.
                SYNC: begin
                    if (!iFVAL)
                        state <= ARMED;
                end

                ARMED: begin
                    if (!iENABLE) begin
                        state <= IDLE;
                    end else if (frame_start) begin
                        state     <= LOAD;
                        load_r    <= 1'b1;
                        load_cnt  <= LOAD_LAST;
                        end_pend  <= 1'b0;
                        pixel_cnt <= '0;
                        oDROP_CNT <= '0;
                        oOVERFLOW <= 1'b0;
                    end
                end

                LOAD: begin
                    if (pix_vld) begin
                        oDROP_CNT <= sat_inc16(oDROP_CNT);
                        oOVERFLOW <= 1'b1;
                    end
                    if (frame_end)
                        end_pend <= 1'b1;
                    // A frame that ends mid-pulse still gets its full reload first.
                    if (load_cnt == 4'd0) begin
                        load_r <= 1'b0;
                        if (end_pend || frame_end) begin
                            end_pend   <= 1'b0;
                            oFRAME_CNT <= oFRAME_CNT + 16'd1;
                            oSIZE_ERR  <= (pixel_cnt != FRAME_PIX);
                            state      <= iENABLE ? ARMED : IDLE;
                        end else begin
                            state <= ACTIVE;
                        end
                    end else begin
                        load_cnt <= load_cnt - 4'd1;
                    end
                end

                ACTIVE: begin
                    if (frame_end) begin
                        oFRAME_CNT <= oFRAME_CNT + 16'd1;
                        oSIZE_ERR  <= (pixel_cnt != FRAME_PIX);
                        state      <= iENABLE ? ARMED : IDLE;
                    end else if (pix_vld) begin
                        if (!iWR1_FULL && !iWR2_FULL) begin
                            wr_p1       <= 1'b1;
                            wr1_data_p1 <= words.wr1;
                            wr2_data_p1 <= words.wr2;
                            pixel_cnt   <= sat_inc20(pixel_cnt);
                        end else begin
                            oDROP_CNT <= sat_inc16(oDROP_CNT);
                            oOVERFLOW <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Scoreboard bench for sdram_frame_writer with a shortened frame length.
module tb_sdram_frame_writer;

    localparam int FP = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        iENABLE, iFVAL, iLVAL, iDVAL;
    logic [9:0]  iRED, iGREEN, iBLUE;
    logic        iWR1_FULL, iWR2_FULL;
    logic [15:0] WR1_DATA, WR2_DATA;
    logic        WR1, WR2;
    logic [21:0] WR1_ADDR, WR2_ADDR, WR1_MAX_ADDR, WR2_MAX_ADDR;
    logic [8:0]  WR1_LENGTH, WR2_LENGTH;
    logic        WR1_LOAD, WR2_LOAD;
    logic [15:0] oFRAME_CNT, oDROP_CNT;
    logic        oOVERFLOW, oSIZE_ERR, oBUSY;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    sdram_frame_writer #(.FRAME_PIXELS(FP)) dut (
        .CLK(CLK), .RESET(RESET), .iENABLE(iENABLE), .iFVAL(iFVAL),
        .iLVAL(iLVAL), .iDVAL(iDVAL), .iRED(iRED), .iGREEN(iGREEN),
        .iBLUE(iBLUE), .iWR1_FULL(iWR1_FULL), .iWR2_FULL(iWR2_FULL),
        .WR1_DATA(WR1_DATA), .WR2_DATA(WR2_DATA), .WR1(WR1), .WR2(WR2),
        .WR1_ADDR(WR1_ADDR), .WR2_ADDR(WR2_ADDR),
        .WR1_MAX_ADDR(WR1_MAX_ADDR), .WR2_MAX_ADDR(WR2_MAX_ADDR),
        .WR1_LENGTH(WR1_LENGTH), .WR2_LENGTH(WR2_LENGTH),
        .WR1_LOAD(WR1_LOAD), .WR2_LOAD(WR2_LOAD),
        .oFRAME_CNT(oFRAME_CNT), .oDROP_CNT(oDROP_CNT),
        .oOVERFLOW(oOVERFLOW), .oSIZE_ERR(oSIZE_ERR), .oBUSY(oBUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pix(input logic [9:0] r, input logic [9:0] g,
                            input logic [9:0] b, input bit wr);
        iRED = r; iGREEN = g; iBLUE = b;
        iLVAL = 1'b1; iDVAL = 1'b1;
        if (wr)
            exp_q.push_back({1'b0, g[9:5], b, 1'b0, g[4:0], r});
        tick();
        iLVAL = 1'b0; iDVAL = 1'b0;
    endtask

    task automatic count_load(input int cyc, output int n);
        n = 0;
        repeat (cyc) begin
            @(negedge CLK);
            if (WR1_LOAD && WR2_LOAD)
                n++;
        end
    endtask

    // Write monitor: every request pair must match the oldest queued pixel.
    always @(negedge CLK) begin
        if (!RESET && (WR1 || WR2)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write WR1=%0b WR2=%0b data=%h/%h at %0t",
                         WR1, WR2, WR1_DATA, WR2_DATA, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("wr_pair", {30'd0, WR1, WR2}, 32'd3);
                check("wr_data", {WR1_DATA, WR2_DATA}, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        RESET = 1'b1; iENABLE = 1'b0; iFVAL = 1'b0; iLVAL = 1'b0; iDVAL = 1'b0;
        iRED = '0; iGREEN = '0; iBLUE = '0; iWR1_FULL = 1'b0; iWR2_FULL = 1'b0;
        ticks(3);

        check("rst_wr",       {30'd0, WR1, WR2}, 32'd0);
        check("rst_load",     {30'd0, WR1_LOAD, WR2_LOAD}, 32'd0);
        check("rst_flags",    {29'd0, oOVERFLOW, oSIZE_ERR, oBUSY}, 32'd0);
        check("rst_cnts",     {oFRAME_CNT, oDROP_CNT}, 32'd0);
        check("rst_data",     {WR1_DATA, WR2_DATA}, 32'd0);
        check("addr1",        32'(WR1_ADDR), 32'h000000);
        check("addr2",        32'(WR2_ADDR), 32'h100000);
        check("max1",         32'(WR1_MAX_ADDR), 32'h000010);
        check("max2",         32'(WR2_MAX_ADDR), 32'h100010);
        check("length",       {7'd0, WR1_LENGTH, 7'd0, WR2_LENGTH}, {16'd256, 16'd256});

        // Frame 1: exact length with three drops on FIFO 2 full.
        RESET = 1'b0; iENABLE = 1'b1;
        ticks(3);
        check("busy_armed", 32'(oBUSY), 32'd1);
        iFVAL = 1'b1;
        count_load(12, n);
        check("load_len_f1", 32'(n), 32'd4);
        check("drop_f1_start", 32'(oDROP_CNT), 32'd0);
        check("busy_f1", 32'(oBUSY), 32'd1);
        send_pix(10'h3FF, 10'h2AA, 10'h155, 1'b0);
        exp_q.push_back(32'h5555_2BFF);
        ticks(2);
        iWR2_FULL = 1'b1;
        for (int i = 0; i < 3; i++) send_pix(10'(i), 10'(i + 1), 10'(i + 2), 1'b0);
        check("drop_cnt_3", 32'(oDROP_CNT), 32'd3);
        check("overflow_set", 32'(oOVERFLOW), 32'd1);
        iWR2_FULL = 1'b0;
        for (int i = 1; i < FP; i++) send_pix(10'(i * 37), 10'(i * 91), 10'(i * 13), 1'b1);
        iFVAL = 1'b0;
        ticks(2);
        check("frame_cnt_1", 32'(oFRAME_CNT), 32'd1);
        check("size_err_f1", 32'(oSIZE_ERR), 32'd0);
        check("drop_hold", {15'd0, oOVERFLOW, oDROP_CNT}, {15'd0, 1'b1, 16'd3});

        // Frame 2: one pixel short.
        iFVAL = 1'b1;
        count_load(12, n);
        check("load_len_f2", 32'(n), 32'd4);
        check("drop_clear", {15'd0, oOVERFLOW, oDROP_CNT}, 32'd0);
        for (int i = 0; i < FP - 1; i++) send_pix(10'(1000 - i), 10'(i * 5), 10'(i ^ 10'h2A5), 1'b1);
        iFVAL = 1'b0;
        ticks(2);
        check("frame_cnt_2", 32'(oFRAME_CNT), 32'd2);
        check("size_err_f2", 32'(oSIZE_ERR), 32'd1);

        // Frame 3: pixels during LOAD are dropped; enable falls mid-frame.
        iFVAL = 1'b1;
        tick();
        send_pix(10'h001, 10'h002, 10'h003, 1'b0);
        send_pix(10'h004, 10'h005, 10'h006, 1'b0);
        ticks(4);
        check("load_drops", {15'd0, oOVERFLOW, oDROP_CNT}, {15'd0, 1'b1, 16'd2});
        iENABLE = 1'b0;
        for (int i = 0; i < FP; i++) send_pix(10'(i * 3), 10'(i * 7), 10'(i * 11), 1'b1);
        iFVAL = 1'b0;
        ticks(2);
        check("frame_cnt_3", 32'(oFRAME_CNT), 32'd3);
        check("size_err_f3", 32'(oSIZE_ERR), 32'd0);
        check("idle_after_dis", 32'(oBUSY), 32'd0);

        // Frame 4: enable while a frame is in flight; no capture until next start.
        iFVAL = 1'b1;
        ticks(2);
        iENABLE = 1'b1;
        tick();
        send_pix(10'h111, 10'h222, 10'h333, 1'b0);
        send_pix(10'h044, 10'h055, 10'h066, 1'b0);
        iFVAL = 1'b0;
        count_load(3, n);
        check("no_load_midframe", 32'(n), 32'd0);
        check("frame_cnt_hold", 32'(oFRAME_CNT), 32'd3);
        iFVAL = 1'b1;
        count_load(12, n);
        check("load_len_f4", 32'(n), 32'd4);
        send_pix(10'h0F0, 10'h30F, 10'h1E1, 1'b1);
        iFVAL = 1'b0;
        ticks(2);
        check("frame_cnt_4", 32'(oFRAME_CNT), 32'd4);
        check("size_err_f4", 32'(oSIZE_ERR), 32'd1);

        // Reset in the second LOAD cycle.
        iFVAL = 1'b1;
        ticks(2);
        check("load_c2", 32'(WR1_LOAD), 32'd1);
        RESET = 1'b1;
        #1;
        check("load_cut", {30'd0, WR1_LOAD, WR2_LOAD}, 32'd0);
        check("rst_mid_cnts", {oFRAME_CNT, 15'd0, oBUSY}, 32'd0);
        ticks(2);
        RESET = 1'b0;
        count_load(10, n);
        check("no_load_after_rst", 32'(n), 32'd0);
        iFVAL = 1'b0;
        ticks(2);
        iFVAL = 1'b1;
        count_load(12, n);
        check("load_after_resync", 32'(n), 32'd4);
        check("busy_resync", 32'(oBUSY), 32'd1);

        ticks(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
